// File: rtl/unsigned_arith_pkg.sv
// Shared definitions for the unsigned arithmetic blocks: default widths,
// divider FSM states and the divide-by-zero result encoding.
package unsigned_arith_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned VW_DEF = 8;
  localparam int unsigned CW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Divide by zero: quotient saturates to all-ones, remainder is the low dividend slice.
  localparam logic        DZ_Q_BIT  = 1'b1;
  localparam int unsigned DZ_R_LSB  = 0;

endpackage

// File: rtl/div_step_restoring.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step_restoring #(
  parameter int unsigned VW = 8
) (
  input  logic [VW:0]   rem,
  input  logic          qbit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic          qbit_out
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] dvs_ext;

  assign shifted  = {rem, qbit_in};
  assign dvs_ext  = (VW+2)'(divisor);
  assign qbit_out = (shifted >= dvs_ext);
  // Remainder stays below the divisor, so the result always fits in VW+1 bits.
  assign rem_next = (VW+1)'(qbit_out ? (shifted - dvs_ext) : shifted);

endmodule

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential restoring divider, one quotient bit per clock, behind a
// valid/ready stream with a single operation in flight.
module unsigned_divider_16by8_seq
  import unsigned_arith_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] z,
  input  logic [VW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dz
);

  div_state_t    state;
  logic [VW:0]   rem;
  logic [DW-1:0] qreg;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic [VW:0]   rem_next;
  logic          qbit;

  div_step_restoring #(.VW(VW)) u_step (
    .rem      (rem),
    .qbit_in  (qreg[DW-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .qbit_out (qbit)
  );

  // Control FSM plus datapath registers; out_valid rises one edge after DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      dz        <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      qreg      <= '0;
      dvs       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            qreg     <= z;
            dvs      <= y;
            rem      <= '0;
            in_ready <= 1'b0;
            if (y == '0) begin
              q     <= {DW{DZ_Q_BIT}};
              r     <= z[DZ_R_LSB +: VW];
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= CW'(DW - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem  <= rem_next;
          qreg <= {qreg[DW-2:0], qbit};
          if (cnt == '0) begin
            q     <= {qreg[DW-2:0], qbit};
            r     <= rem_next[VW-1:0];
            dz    <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_divider_16by8_seq.sv
// Randomized self-checking bench for the sequential 16/8 divider against
// a plain-arithmetic quotient/remainder model.
module tb_unsigned_divider_16by8_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;

  unsigned_divider_16by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_dz;
  logic        exp_valid = 1'b0;
  bit          after_hs  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every cycle a result is presented it must match the model and block new input.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (exp_valid !== 1'b1) begin
        chk("spurious_out_valid", 32'(out_valid), 32'(exp_valid));
      end else begin
        chk("q", 32'(q), 32'(exp_q));
        chk("r", 32'(r), 32'(exp_r));
        chk("dz", 32'(dz), 32'(exp_dz));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
    end
  end

  // Present operands, wait for acceptance and arm the reference model.
  task automatic accept(input logic [15:0] zz, input logic [7:0] yy);
    int  n;
    bit  ok;
    z        = zz;
    y        = yy;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      if (after_hs) begin
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        after_hs = 1'b0;
      end
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    z        = 16'($urandom);
    y        = 8'($urandom);
    exp_dz    = (yy == 8'd0);
    exp_q     = (yy == 8'd0) ? 16'hFFFF : zz / 16'(yy);
    exp_r     = (yy == 8'd0) ? zz[7:0] : 8'(zz % 16'(yy));
    exp_valid = 1'b1;
  endtask

  task automatic run_op(input logic [15:0] zz, input logic [7:0] yy, input int hold,
                        input bit early_rdy, input bit lit, input logic [15:0] lq,
                        input logic [7:0] lr, input bit next_in_done,
                        input logic [15:0] nz, input logic [7:0] ny);
    int lat;
    accept(zz, yy);
    if (early_rdy) out_ready = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 32'(lat), (yy == 8'd0) ? 32'd1 : 32'd17);
    if (lit) begin
      chk("lit_q", 32'(q), 32'(lq));
      chk("lit_r", 32'(r), 32'(lr));
    end
    if (yy != 8'd0) begin
      chk("identity", 32'(q) * 32'(yy) + 32'(r), 32'(zz));
      chk("r_lt_y", 32'(r < yy), 32'd1);
    end
    if (next_in_done) begin
      z        = nz;
      y        = ny;
      in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    after_hs  = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  xx;
    logic [7:0]  yy;
    logic [15:0] zz;
    int          hold;
    bit          early;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    y         = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(16'd15000, 8'd100, 0, 1'b0, 1'b1, 16'd150,   8'd0,   1'b0, '0, '0);
    run_op(16'd12345, 8'd7,   1, 1'b0, 1'b1, 16'd1763,  8'd4,   1'b0, '0, '0);
    run_op(16'd65535, 8'd255, 0, 1'b0, 1'b1, 16'd257,   8'd0,   1'b0, '0, '0);
    run_op(16'd65535, 8'd1,   0, 1'b0, 1'b1, 16'd65535, 8'd0,   1'b0, '0, '0);
    run_op(16'd1000,  8'd0,   0, 1'b1, 1'b1, 16'hFFFF,  8'hE8,  1'b0, '0, '0);
    run_op(16'd0,     8'd5,   0, 1'b0, 1'b1, 16'd0,     8'd0,   1'b0, '0, '0);
    run_op(16'd200,   8'd9,   5, 1'b0, 1'b1, 16'd22,    8'd2,   1'b1, 16'd7, 8'd2);
    run_op(16'd7,     8'd2,   0, 1'b0, 1'b1, 16'd3,     8'd1,   1'b0, '0, '0);

    // Abort mid-operation with an asynchronous reset.
    accept(16'd40000, 8'd3);
    repeat (8) @(posedge clk);
    #2;
    rst       = 1'b1;
    exp_valid = 1'b0;
    after_hs  = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_no_result", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    run_op(16'd40000, 8'd3, 0, 1'b0, 1'b1, 16'd13333, 8'd1, 1'b0, '0, '0);

    // Product/operand round trips.
    for (int i = 0; i < 300; i++) begin
      xx   = 8'($urandom_range(0, 255));
      yy   = 8'($urandom_range(1, 255));
      zz   = 16'(xx) * 16'(yy);
      hold = $urandom_range(0, 2);
      run_op(zz, yy, hold, 1'b0, 1'b1, 16'(xx), 8'd0, 1'b0, '0, '0);
    end

    // Random operands, occasional zero divisor and early out_ready.
    for (int i = 0; i < 2200; i++) begin
      zz    = 16'($urandom);
      yy    = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      hold  = $urandom_range(0, 2);
      early = (hold == 0) && ($urandom_range(0, 3) == 0);
      run_op(zz, yy, hold, early, 1'b0, '0, '0, 1'b0, '0, '0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
